// File: rtl/riscv_apu_wb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_apu_wb_buffer_pkg
// Description : Shared constants and helpers for the APU writeback buffer.
//               APU_WB_DEPTH        - default number of buffered results
//               APU_REG_ADDR_WIDTH  - register-file address width
//               APU_FLAGS_WIDTH     - FP exception flag width
//               APU_NUM_READ_PORTS  - ID-stage source operands checked
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_apu_wb_buffer_pkg;

    localparam int APU_WB_DEPTH       = 2;
    localparam int APU_REG_ADDR_WIDTH = 6;
    localparam int APU_FLAGS_WIDTH    = 5;
    localparam int APU_NUM_READ_PORTS = 3;

    // Pointer width for a buffer of the given depth (at least one bit).
    function automatic int apu_wb_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_apu_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_apu_wb_buffer_if
// Description : APU response channel between the dispatcher (master) and the
//               writeback buffer (slave). Signal names keep the buffer-side
//               direction suffix so they read the same as the buffer ports.
//               apu_result_valid_i - result valid
//               apu_waddr_i        - destination register
//               apu_result_i       - result data
//               apu_flags_i        - FP exception flags
//               apu_ready_o        - buffer can accept a result
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_apu_wb_buffer_if
    import riscv_apu_wb_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FLAGS_WIDTH = APU_FLAGS_WIDTH
);

    logic                          apu_result_valid_i;
    logic [APU_REG_ADDR_WIDTH-1:0] apu_waddr_i;
    logic [DATA_WIDTH-1:0]         apu_result_i;
    logic [FLAGS_WIDTH-1:0]        apu_flags_i;
    logic                          apu_ready_o;

    modport master (
        output apu_result_valid_i,
        output apu_waddr_i,
        output apu_result_i,
        output apu_flags_i,
        input  apu_ready_o
    );

    modport slave (
        input  apu_result_valid_i,
        input  apu_waddr_i,
        input  apu_result_i,
        input  apu_flags_i,
        output apu_ready_o
    );

endinterface
`default_nettype wire

// File: rtl/riscv_apu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : riscv_apu_wb_fifo
// Description : In-order result storage for the APU writeback buffer.
//               Holds waddr/data (and flags when APU_WB_FLAGS_EN is defined),
//               head/tail pointers and occupancy count. Exposes per-entry
//               destination and valid vectors for the ID-stage hazard check.
//               Ports: clk_i, rst_ni (async, active-low), push_i/waddr_i/
//               data_i/flags_i (write side), pop_i (drain head), head_*_o,
//               empty_o, full_o, entry_waddr_o, entry_valid_o.
//               Configuration macro: APU_WB_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_apu_wb_fifo
    import riscv_apu_wb_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FLAGS_WIDTH = APU_FLAGS_WIDTH,
    parameter int DEPTH       = APU_WB_DEPTH   // 2 or 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      push_i,
    input  logic [APU_REG_ADDR_WIDTH-1:0]             waddr_i,
    input  logic [DATA_WIDTH-1:0]                     data_i,
    input  logic [FLAGS_WIDTH-1:0]                    flags_i,
    input  logic                                      pop_i,
    output logic [APU_REG_ADDR_WIDTH-1:0]             head_waddr_o,
    output logic [DATA_WIDTH-1:0]                     head_data_o,
    output logic [FLAGS_WIDTH-1:0]                    head_flags_o,
    output logic                                      empty_o,
    output logic                                      full_o,
    output logic [DEPTH-1:0][APU_REG_ADDR_WIDTH-1:0]  entry_waddr_o,
    output logic [DEPTH-1:0]                          entry_valid_o
);

    localparam int                 c_PTR_W    = apu_wb_ptr_width(DEPTH);
    localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0]                       r_head;
    logic [c_PTR_W-1:0]                       r_tail;
    logic [c_CNT_W-1:0]                       r_count;
    logic [DEPTH-1:0][APU_REG_ADDR_WIDTH-1:0] r_waddr_mem;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]         r_data_mem;

    logic w_do_push;
    logic w_do_pop;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == c_CNT_FULL);
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // Only the valid state is reset; payload storage is qualified by count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= next_ptr(r_tail);
            if (w_do_pop)  r_head <= next_ptr(r_head);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_waddr_mem[r_tail] <= waddr_i;
            r_data_mem[r_tail]  <= data_i;
        end
    end

    assign head_waddr_o  = r_waddr_mem[r_head];
    assign head_data_o   = r_data_mem[r_head];
    assign entry_waddr_o = r_waddr_mem;

`ifdef APU_WB_FLAGS_EN
    logic [DEPTH-1:0][FLAGS_WIDTH-1:0] r_flags_mem;

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_flags_mem[r_tail] <= flags_i;
    end

    assign head_flags_o = r_flags_mem[r_head];
`else
    logic w_unused_flags;
    assign w_unused_flags = ^flags_i;
    assign head_flags_o   = '0;
`endif

    // An entry is live when its distance from the head is below the count.
    // DEPTH is a power of two, so the pointer subtraction wraps correctly.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_valid
        logic [c_PTR_W-1:0] w_offset;
        assign w_offset         = c_PTR_W'(i) - r_head;
        assign entry_valid_o[i] = (c_CNT_W'(w_offset) < r_count);
    end

endmodule
`default_nettype wire

// File: rtl/riscv_apu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : riscv_apu_wb_buffer
// Description : APU result writeback buffer for register-file port B.
//               LSU writeback has priority on port B; APU results are held
//               in arrival order and drained when the port is free, with a
//               zero-latency bypass when empty. Flags buffered destinations
//               against ID-stage sources so decode can stall.
//               Ports: clk_i, rst_ni (async, active-low), apu (slave side of
//               riscv_apu_wb_buffer_if), lsu_wb_busy_i, regfile_we/waddr/
//               wdata_o, fflags_we_o, fflags_o, read_regs_0/1/2_i,
//               read_regs_valid_i, read_dep_o, empty_o, full_o, overflow_o.
//               Configuration macro: APU_WB_FLAGS_EN (per-entry FP flags).
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_apu_wb_buffer
    import riscv_apu_wb_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FLAGS_WIDTH = APU_FLAGS_WIDTH,
    parameter int DEPTH       = APU_WB_DEPTH   // 2 or 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    riscv_apu_wb_buffer_if.slave          apu,
    input  logic                          lsu_wb_busy_i,
    output logic                          regfile_we_o,
    output logic [APU_REG_ADDR_WIDTH-1:0] regfile_waddr_o,
    output logic [DATA_WIDTH-1:0]         regfile_wdata_o,
    output logic                          fflags_we_o,
    output logic [FLAGS_WIDTH-1:0]        fflags_o,
    input  logic [APU_REG_ADDR_WIDTH-1:0] read_regs_0_i,
    input  logic [APU_REG_ADDR_WIDTH-1:0] read_regs_1_i,
    input  logic [APU_REG_ADDR_WIDTH-1:0] read_regs_2_i,
    input  logic [APU_NUM_READ_PORTS-1:0] read_regs_valid_i,
    output logic                          read_dep_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic                          overflow_o
);

    logic                                     w_empty;
    logic                                     w_full;
    logic                                     w_bypass;
    logic                                     w_push;
    logic                                     w_drain;
    logic [APU_REG_ADDR_WIDTH-1:0]            w_head_waddr;
    logic [DATA_WIDTH-1:0]                    w_head_data;
    logic [FLAGS_WIDTH-1:0]                   w_head_flags;
    logic [DEPTH-1:0][APU_REG_ADDR_WIDTH-1:0] w_entry_waddr;
    logic [DEPTH-1:0]                         w_entry_valid;
    logic [APU_NUM_READ_PORTS-1:0][APU_REG_ADDR_WIDTH-1:0] w_read_regs;
    logic                                     r_overflow;

    // Bypass is gated by reset so port B is quiet while reset is held.
    assign w_bypass = rst_ni & w_empty & ~lsu_wb_busy_i & apu.apu_result_valid_i;
    assign w_push   = apu.apu_result_valid_i & ~w_bypass & ~w_full;
    assign w_drain  = ~w_empty & ~lsu_wb_busy_i;

    riscv_apu_wb_fifo #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FLAGS_WIDTH (FLAGS_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (w_push),
        .waddr_i       (apu.apu_waddr_i),
        .data_i        (apu.apu_result_i),
        .flags_i       (apu.apu_flags_i),
        .pop_i         (w_drain),
        .head_waddr_o  (w_head_waddr),
        .head_data_o   (w_head_data),
        .head_flags_o  (w_head_flags),
        .empty_o       (w_empty),
        .full_o        (w_full),
        .entry_waddr_o (w_entry_waddr),
        .entry_valid_o (w_entry_valid)
    );

    assign empty_o         = w_empty;
    assign full_o          = w_full;
    // Registered count only: no path from lsu_wb_busy_i to ready.
    assign apu.apu_ready_o = ~w_full;

    // Port B mux. A non-empty buffer always wins over the input so results
    // leave in arrival order; idle outputs are forced to zero.
    always_comb begin
        regfile_we_o    = 1'b0;
        regfile_waddr_o = '0;
        regfile_wdata_o = '0;
        if (w_drain) begin
            regfile_we_o    = 1'b1;
            regfile_waddr_o = w_head_waddr;
            regfile_wdata_o = w_head_data;
        end else if (w_bypass) begin
            regfile_we_o    = 1'b1;
            regfile_waddr_o = apu.apu_waddr_i;
            regfile_wdata_o = apu.apu_result_i;
        end
    end

`ifdef APU_WB_FLAGS_EN
    assign fflags_we_o = regfile_we_o;
    always_comb begin
        fflags_o = '0;
        if (w_drain)       fflags_o = w_head_flags;
        else if (w_bypass) fflags_o = apu.apu_flags_i;
    end
`else
    logic w_unused_head_flags;
    assign w_unused_head_flags = ^w_head_flags;
    assign fflags_we_o         = 1'b0;
    assign fflags_o            = '0;
`endif

    // Hazard check covers stored entries only; the bypassing result is
    // written this cycle and needs no stall. A draining head still counts.
    assign w_read_regs = {read_regs_2_i, read_regs_1_i, read_regs_0_i};

    always_comb begin
        read_dep_o = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int k = 0; k < APU_NUM_READ_PORTS; k++) begin
                if (w_entry_valid[e] && read_regs_valid_i[k] &&
                    (w_read_regs[k] == w_entry_waddr[e])) begin
                    read_dep_o = 1'b1;
                end
            end
        end
    end

    // Sticky: a result that arrives while full is lost, so keep a record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (apu.apu_result_valid_i && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_riscv_apu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_apu_wb_buffer
// Description : Self-checking bench for riscv_apu_wb_buffer. Directed
//               stimulus pushes expected port-B writes into a queue; a
//               monitor pops and compares on every regfile_we_o.
//               Honors APU_WB_FLAGS_EN for the expected flag outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_apu_wb_buffer;

    typedef struct packed {
        logic [5:0]  waddr;
        logic [31:0] data;
        logic [4:0]  flags;
    } wb_t;

    logic        clk_i;
    logic        rst_ni;
    logic        lsu_wb_busy_i;
    logic        regfile_we_o;
    logic [5:0]  regfile_waddr_o;
    logic [31:0] regfile_wdata_o;
    logic        fflags_we_o;
    logic [4:0]  fflags_o;
    logic [5:0]  read_regs_0_i;
    logic [5:0]  read_regs_1_i;
    logic [5:0]  read_regs_2_i;
    logic [2:0]  read_regs_valid_i;
    logic        read_dep_o;
    logic        empty_o;
    logic        full_o;
    logic        overflow_o;

    wb_t sb_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    riscv_apu_wb_buffer_if #(.DATA_WIDTH(32), .FLAGS_WIDTH(5)) apu_bus ();

    riscv_apu_wb_buffer #(.DATA_WIDTH(32), .FLAGS_WIDTH(5), .DEPTH(2)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .apu               (apu_bus.slave),
        .lsu_wb_busy_i     (lsu_wb_busy_i),
        .regfile_we_o      (regfile_we_o),
        .regfile_waddr_o   (regfile_waddr_o),
        .regfile_wdata_o   (regfile_wdata_o),
        .fflags_we_o       (fflags_we_o),
        .fflags_o          (fflags_o),
        .read_regs_0_i     (read_regs_0_i),
        .read_regs_1_i     (read_regs_1_i),
        .read_regs_2_i     (read_regs_2_i),
        .read_regs_valid_i (read_regs_valid_i),
        .read_dep_o        (read_dep_o),
        .empty_o           (empty_o),
        .full_o            (full_o),
        .overflow_o        (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [5:0] a, input logic [31:0] d,
                         input logic [4:0] f, input logic busy);
        @(posedge clk_i);
        #1;
        apu_bus.apu_result_valid_i = v;
        apu_bus.apu_waddr_i        = a;
        apu_bus.apu_result_i       = d;
        apu_bus.apu_flags_i        = f;
        lsu_wb_busy_i              = busy;
    endtask

    task automatic expect_wb(input logic [5:0] a, input logic [31:0] d, input logic [4:0] f);
        wb_t e;
        e.waddr = a;
        e.data  = d;
        e.flags = f;
        sb_q.push_back(e);
    endtask

    // Monitor: every port-B write must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_ni && regfile_we_o) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected",
                         regfile_waddr_o, regfile_wdata_o);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                chk("wb_waddr", 64'(regfile_waddr_o), 64'(e.waddr));
                chk("wb_wdata", 64'(regfile_wdata_o), 64'(e.data));
`ifdef APU_WB_FLAGS_EN
                chk("wb_fflags_we", 64'(fflags_we_o), 64'd1);
                chk("wb_fflags", 64'(fflags_o), 64'(e.flags));
`else
                chk("wb_fflags_we", 64'(fflags_we_o), 64'd0);
                chk("wb_fflags", 64'(fflags_o), 64'd0);
`endif
            end
        end
    end

    initial begin
        rst_ni                     = 1'b0;
        lsu_wb_busy_i              = 1'b0;
        apu_bus.apu_result_valid_i = 1'b0;
        apu_bus.apu_waddr_i        = '0;
        apu_bus.apu_result_i       = '0;
        apu_bus.apu_flags_i        = '0;
        read_regs_0_i              = '0;
        read_regs_1_i              = '0;
        read_regs_2_i              = '0;
        read_regs_valid_i          = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_empty",     64'(empty_o), 64'd1);
        chk("rst_full",      64'(full_o), 64'd0);
        chk("rst_ready",     64'(apu_bus.apu_ready_o), 64'd1);
        chk("rst_overflow",  64'(overflow_o), 64'd0);
        chk("rst_we",        64'(regfile_we_o), 64'd0);
        chk("rst_waddr",     64'(regfile_waddr_o), 64'd0);
        chk("rst_wdata",     64'(regfile_wdata_o), 64'd0);
        chk("rst_fflags_we", 64'(fflags_we_o), 64'd0);
        chk("rst_fflags",    64'(fflags_o), 64'd0);
        chk("rst_read_dep",  64'(read_dep_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Same-cycle bypass on an idle port
        drive(1'b1, 6'd5, 32'hDEADBEEF, 5'b00001, 1'b0);
        expect_wb(6'd5, 32'hDEADBEEF, 5'b00001);
        #1;
        chk("bypass_we",    64'(regfile_we_o), 64'd1);
        chk("bypass_waddr", 64'(regfile_waddr_o), 64'd5);
        chk("bypass_wdata", 64'(regfile_wdata_o), 64'hDEADBEEF);
        chk("bypass_empty", 64'(empty_o), 64'd1);
        read_regs_0_i     = 6'd5;
        read_regs_valid_i = 3'b001;
        #1;
        chk("bypass_no_dep", 64'(read_dep_o), 64'd0);
        read_regs_valid_i = 3'b000;

        // LSU holds port B for three cycles; two results are buffered
        drive(1'b1, 6'd3, 32'h0000_0033, 5'd0, 1'b1);
        expect_wb(6'd3, 32'h0000_0033, 5'd0);
        drive(1'b1, 6'd7, 32'h0000_0077, 5'd2, 1'b1);
        expect_wb(6'd7, 32'h0000_0077, 5'd2);
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
        #1;
        chk("busy_full",  64'(full_o), 64'd1);
        chk("busy_ready", 64'(apu_bus.apu_ready_o), 64'd0);
        chk("busy_we",    64'(regfile_we_o), 64'd0);
        chk("busy_empty", 64'(empty_o), 64'd0);
        read_regs_1_i     = 6'd7;
        read_regs_valid_i = 3'b010;
        #1;
        chk("dep_r1_hit", 64'(read_dep_o), 64'd1);
        read_regs_valid_i = 3'b000;
        #1;
        chk("dep_r1_masked", 64'(read_dep_o), 64'd0);
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("drained_empty", 64'(empty_o), 64'd1);
        chk("drained_we",    64'(regfile_we_o), 64'd0);

        // Third result while full is dropped and overflow latches
        drive(1'b1, 6'd9, 32'h0000_0099, 5'd3, 1'b1);
        expect_wb(6'd9, 32'h0000_0099, 5'd3);
        drive(1'b1, 6'd10, 32'h0000_00AA, 5'd4, 1'b1);
        expect_wb(6'd10, 32'h0000_00AA, 5'd4);
        drive(1'b1, 6'd11, 32'h0000_00BB, 5'd5, 1'b1);
        #1;
        chk("ovf_before_edge", 64'(overflow_o), 64'd0);
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
        #1;
        chk("ovf_set",  64'(overflow_o), 64'd1);
        chk("ovf_full", 64'(full_o), 64'd1);
        read_regs_1_i     = 6'd9;
        read_regs_valid_i = 3'b010;
        #1;
        chk("dep_r9", 64'(read_dep_o), 64'd1);
        read_regs_valid_i = 3'b000;
        #1;
        chk("dep_r9_masked", 64'(read_dep_o), 64'd0);
        read_regs_2_i     = 6'd10;
        read_regs_valid_i = 3'b100;
        #1;
        chk("dep_r10_port2", 64'(read_dep_o), 64'd1);
        read_regs_valid_i = 3'b000;
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("ovf_sticky",    64'(overflow_o), 64'd1);
        chk("ovf_drained",   64'(empty_o), 64'd1);

        // Ten back-to-back results with one entry held: push and drain together
        drive(1'b1, 6'd12, 32'h1000_0000, 5'd0, 1'b1);
        expect_wb(6'd12, 32'h1000_0000, 5'd0);
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 6'(12 + i), 32'h1000_0000 + 32'(i), 5'(i), 1'b0);
            expect_wb(6'(12 + i), 32'h1000_0000 + 32'(i), 5'(i));
            #1;
            chk("stream_not_empty", 64'(empty_o), 64'd0);
            chk("stream_not_full",  64'(full_o), 64'd0);
        end
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("stream_empty", 64'(empty_o), 64'd1);

        // Reset with two entries buffered discards them immediately
        drive(1'b1, 6'd20, 32'h0000_0020, 5'd1, 1'b1);
        expect_wb(6'd20, 32'h0000_0020, 5'd1);
        drive(1'b1, 6'd21, 32'h0000_0021, 5'd1, 1'b1);
        expect_wb(6'd21, 32'h0000_0021, 5'd1);
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
        #1;
        chk("pre_rst_full", 64'(full_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_empty",    64'(empty_o), 64'd1);
        chk("mid_rst_we",       64'(regfile_we_o), 64'd0);
        chk("mid_rst_full",     64'(full_o), 64'd0);
        chk("mid_rst_overflow", 64'(overflow_o), 64'd0);
        chk("mid_rst_ready",    64'(apu_bus.apu_ready_o), 64'd1);
        sb_q.delete();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("post_rst_empty", 64'(empty_o), 64'd1);
        @(negedge clk_i);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
